// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer state encoding and the
// helper that sizes the word index from the memory depth.
package apb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  // Number of index bits needed to address 'depth' words (at least 1).
  function automatic int unsigned idx_width(input int unsigned depth);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/apb_byte_regfile.sv
// DEPTH x 32-bit local memory for the APB completer.
// Synchronous clear on PRESET, byte-enable write port, combinational read.
//   PCLK   : rising-edge clock
//   PRESET : synchronous active-high reset, clears every word
//   we     : write enable for this cycle
//   widx   : write word index
//   wstrb  : write byte lanes
//   wdata  : write data
//   ridx   : read word index
//   rdata  : read data (combinational)
module apb_byte_regfile
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3/APB4 completer with a byte-writable, word-addressed local memory,
// programmable wait states and PSLVERR on bad addresses.
//   PCLK    : rising-edge clock
//   PRESET  : synchronous active-high reset
//   PSEL    : completer select
//   PENABLE : access-phase indicator
//   PWRITE  : 1 = write, 0 = read
//   PADDR   : byte address (bit 31 already decoded into PSEL)
//   PWDATA  : write data
//   PSTRB   : write byte lanes
//   PREADY  : registered ready
//   PRDATA  : registered read data
//   PSLVERR : registered error response
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  input  logic [STRB_W-1:0] PSTRB,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = 4;

  apb_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ready_q, ready_n;
  logic              err_q, err_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;

  logic              lat_write, lat_write_n;
  logic              lat_err, lat_err_n;
  logic [IDX_W-1:0]  lat_idx, lat_idx_n;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_n;
  logic [STRB_W-1:0] lat_strb, lat_strb_n;

  logic              addr_err;
  logic [IDX_W-1:0]  addr_idx;
  logic              cur_write, cur_err;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              load_resp;
  logic              unused_paddr31;

  assign unused_paddr31 = PADDR[31];

  assign addr_idx = PADDR[2 +: IDX_W];
  assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR[30:2] >= 29'(DEPTH));

  // With zero wait states the response is loaded on the setup edge itself,
  // before anything has been latched, so decode straight from the bus there.
  assign cur_write = (state == IDLE) ? PWRITE   : lat_write;
  assign cur_err   = (state == IDLE) ? addr_err : lat_err;
  assign rd_idx    = (state == IDLE) ? addr_idx : lat_idx;

  apb_byte_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .we     (mem_we),
    .widx   (lat_idx),
    .wstrb  (lat_strb),
    .wdata  (lat_wdata),
    .ridx   (rd_idx),
    .rdata  (mem_rdata)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_strb  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ready_q   <= ready_n;
      err_q     <= err_n;
      rdata_q   <= rdata_n;
      lat_write <= lat_write_n;
      lat_err   <= lat_err_n;
      lat_idx   <= lat_idx_n;
      lat_wdata <= lat_wdata_n;
      lat_strb  <= lat_strb_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    ready_n     = ready_q;
    err_n       = err_q;
    rdata_n     = rdata_q;
    lat_write_n = lat_write;
    lat_err_n   = lat_err;
    lat_idx_n   = lat_idx;
    lat_wdata_n = lat_wdata;
    lat_strb_n  = lat_strb;
    mem_we      = 1'b0;
    load_resp   = 1'b0;

    case (state)
      IDLE: begin
        // PSEL with PENABLE but no preceding setup is ignored here.
        if (PSEL && !PENABLE) begin
          lat_write_n = PWRITE;
          lat_err_n   = addr_err;
          lat_idx_n   = addr_idx;
          lat_wdata_n = PWDATA;
          lat_strb_n  = PSTRB;
          cnt_n       = CNT_W'(WAIT_CYCLES);
          state_n     = ACCESS;
          if (WAIT_CYCLES == 0) begin
            ready_n   = 1'b1;
            load_resp = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!ready_q) begin
          if (PSEL) begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              ready_n   = 1'b1;
              load_resp = 1'b1;
            end
          end else begin
            state_n = IDLE;
          end
        end else begin
          mem_we  = PSEL && PENABLE && lat_write && !lat_err;
          ready_n = 1'b0;
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (load_resp) begin
      if (cur_err) begin
        err_n   = 1'b1;
        rdata_n = '0;
      end else begin
        err_n = 1'b0;
        if (!cur_write) rdata_n = mem_rdata;
      end
    end
  end

  assign PREADY  = ready_q;
  assign PSLVERR = err_q;
  assign PRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
module tb_apb_slave_mem;

  localparam int NT = 3;
  localparam int NV = 22;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [NT-1:0] psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready  [NT];
  logic [31:0] prdata  [NT];
  logic        pslverr [NT];

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(3)) dut2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));

  int waits [NT] = '{0, 2, 3};

  typedef struct {
    int          tgt;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  vec_t        vec [NV];
  exp_t        sb [$];
  logic [31:0] last_rd [NT];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    @(negedge PCLK);
    psel    = '0;
    penable = 1'b0;
  endtask

  // One transfer; leaves the bus in its completion cycle so a following
  // call forms a back-to-back setup.
  task automatic xfer(input int t, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    exp_t got;
    int   n;
    e.err    = exp_err;
    e.rdata  = exp_err ? 32'h0 : (w ? last_rd[t] : exp_rd);
    e.cycles = waits[t] + 1;
    sb.push_back(e);
    @(negedge PCLK);
    psel    = '0;
    psel[t] = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    @(negedge PCLK);
    penable = 1'b1;
    n = 1;
    while (!pready[t] && n <= 20) begin
      chk($sformatf("prdata_hold t%0d a%08h", t, a), prdata[t], last_rd[t]);
      @(negedge PCLK);
      n++;
    end
    got = sb.pop_front();
    if (!pready[t]) begin
      chk($sformatf("timeout t%0d a%08h", t, a), 32'(pready[t]), 32'd1);
    end else begin
      chk($sformatf("cycles t%0d a%08h", t, a), 32'(n), 32'(got.cycles));
      chk($sformatf("pslverr t%0d a%08h", t, a), 32'(pslverr[t]), 32'(got.err));
      chk($sformatf("prdata t%0d a%08h", t, a), prdata[t], got.rdata);
      last_rd[t] = got.rdata;
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int t = 0; t < NT; t++) begin
      chk($sformatf("%s pready t%0d", tag, t), 32'(pready[t]), 32'd0);
      chk($sformatf("%s pslverr t%0d", tag, t), 32'(pslverr[t]), 32'd0);
      chk($sformatf("%s prdata t%0d", tag, t), prdata[t], 32'h0);
    end
  endtask

  initial begin
    vec[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vec[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0};
    vec[2]  = '{0, 1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    vec[3]  = '{0, 1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    vec[4]  = '{0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    vec[5]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0,         1'b0};
    vec[6]  = '{0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    vec[7]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0,         1'b0};
    vec[8]  = '{0, 1'b0, 32'h0000_0002, 32'h0,         4'hF, 32'h0,         1'b1};
    vec[9]  = '{0, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    vec[10] = '{0, 1'b0, 32'h0000_0008, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0};
    vec[11] = '{0, 1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
    vec[12] = '{0, 1'b0, 32'h0000_000C, 32'h0,         4'hF, 32'h0,         1'b0};
    vec[13] = '{0, 1'b1, 32'h0000_00FC, 32'h0BAD_C0DE, 4'hF, 32'h0,         1'b0};
    vec[14] = '{0, 1'b0, 32'h0000_00FC, 32'h0,         4'hF, 32'h0BAD_C0DE, 1'b0};
    vec[15] = '{0, 1'b1, 32'h0000_0003, 32'h7777_7777, 4'hF, 32'h0,         1'b1};
    vec[16] = '{0, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 32'h0,         1'b0};
    vec[17] = '{1, 1'b1, 32'h0000_0008, 32'h5A5A_5A5A, 4'hF, 32'h0,         1'b0};
    vec[18] = '{1, 1'b0, 32'h0000_0008, 32'h0,         4'hF, 32'h5A5A_5A5A, 1'b0};
    vec[19] = '{1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'h0,         1'b1};
    vec[20] = '{2, 1'b1, 32'h0000_0020, 32'h0102_0304, 4'hF, 32'h0,         1'b0};
    vec[21] = '{2, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'h0102_0304, 1'b0};

    for (int t = 0; t < NT; t++) last_rd[t] = 32'h0;
    PRESET  = 1'b1;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk_zero("reset");

    // Table: consecutive entries on one target run back-to-back.
    for (int i = 0; i < NV; i++)
      xfer(vec[i].tgt, vec[i].write, vec[i].addr, vec[i].wdata, vec[i].strb,
           vec[i].exp_rdata, vec[i].exp_err);
    go_idle();

    // Access phase without setup must be ignored.
    @(negedge PCLK);
    psel[0] = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 32'h10;
    repeat (2) begin
      @(negedge PCLK);
      chk("no_setup pready", 32'(pready[0]), 32'd0);
    end
    go_idle();

    // Master abort during wait states: no write, next setup accepted.
    @(negedge PCLK);
    psel[2] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'hFFFF_FFFF;
    pstrb   = 4'hF;
    @(negedge PCLK);
    penable = 1'b1;
    chk("abort pready0", 32'(pready[2]), 32'd0);
    @(negedge PCLK);
    psel    = '0;
    penable = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      chk("abort idle pready", 32'(pready[2]), 32'd0);
    end
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 32'h0102_0304, 1'b0);
    go_idle();

    // Reset in the middle of an access phase.
    @(negedge PCLK);
    psel[2] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'hFFFF_FFFF;
    pstrb   = 4'hF;
    @(negedge PCLK);
    penable = 1'b1;
    @(negedge PCLK);
    chk("rst_mid pready0", 32'(pready[2]), 32'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET  = 1'b0;
    psel    = '0;
    penable = 1'b0;
    chk_zero("rst_mid");
    for (int t = 0; t < NT; t++) last_rd[t] = 32'h0;
    xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'hFC, 32'h0, 4'hF, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'hF, 32'h0, 1'b0);
    go_idle();

    // Back-to-back writes then reads at zero wait states.
    xfer(0, 1'b1, 32'h30, 32'hA1A1_0001, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h34, 32'hB2B2_0002, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h38, 32'hC3C3_0003, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, 32'hA1A1_0001, 1'b0);
    xfer(0, 1'b0, 32'h34, 32'h0, 4'hF, 32'hB2B2_0002, 1'b0);
    xfer(0, 1'b0, 32'h38, 32'h0, 4'hF, 32'hC3C3_0003, 1'b0);
    go_idle();
    @(negedge PCLK);
    chk("end pready", 32'(pready[0]), 32'd0);
    chk("sb empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB3/APB4 completer that answers the transfers issued by master_bridge on one PSELx line. Holds a byte-writable, word-addressed local memory. Inserts a programmable number of wait states and flags bad addresses on PSLVERR. Two instances sit behind the master: PSEL1 selects the low window and PSEL2 selects the high window (PADDR[31]).

Parameters:
DEPTH, 64, number of 32-bit words in local memory (power of two, 2..1024)
WAIT_CYCLES, 0, wait states inserted before PREADY in every access phase (0..15)

Ports:
PCLK  in  1  clock; all logic is rising-edge
PRESET  in  1  synchronous active-high reset
PSEL  in  1  select from master (PSEL1 or PSEL2)
PENABLE  in  1  access-phase indicator
PWRITE  in  1  1 = write, 0 = read
PADDR  in  32  byte address; bit 31 is ignored because it is already decoded into PSEL
PWDATA  in  32  write data
PSTRB  in  4  write byte lanes; PSTRB[i] enables PWDATA[8i+7:8i]
PREADY  out  1  transfer completes on a rising edge where PSEL, PENABLE and PREADY are all 1
PRDATA  out  32  read data, valid while PREADY=1 and PWRITE=0
PSLVERR  out  1  error response, valid only while PREADY=1

Behaviour:
- Reset (PRESET=1 at a rising edge):
  - state goes to IDLE; PREADY=0, PRDATA=0, PSLVERR=0.
  - All memory words clear to 0.
  - Reset has priority over every other event.
  - Reset during ACCESS abandons the transfer; no memory write occurs.
- All outputs are registered.
- Address decode uses PADDR[30:0]:
  - word index = PADDR[2 +: log2(DEPTH)].
  - Error if PADDR[1:0] != 0, or if PADDR[30:2] >= DEPTH.
- States: IDLE, ACCESS.
- IDLE:
  - A setup phase (PSEL=1, PENABLE=0) latches PWRITE, PADDR, PWDATA, PSTRB and the error flag.
  - On that edge: cnt <= WAIT_CYCLES; go to ACCESS.
  - If WAIT_CYCLES=0, PREADY <= 1 on the same edge, together with the response values (below).
  - PSEL=1 with PENABLE=1 in IDLE (access phase with no setup) is ignored; stay in IDLE with PREADY=0.
- Response values, loaded on the same edge that sets PREADY=1:
  - Read, no error: PRDATA <= mem[index].
  - Error (read or write): PSLVERR <= 1 and PRDATA <= 0.
  - Write, no error: PRDATA holds its previous value.
- ACCESS, PREADY=0:
  - If PSEL=1: cnt decrements. When cnt becomes 0, PREADY <= 1 and the response values are loaded.
  - If PSEL=0 (master abort): go to IDLE; no write occurs.
- ACCESS, PREADY=1:
  - Completion edge (PSEL & PENABLE): if write and no error, each mem byte lane with PSTRB[i]=1 is updated.
  - PREADY <= 0 and PSLVERR <= 0; go to IDLE.
  - Consequence: the access phase lasts WAIT_CYCLES+1 cycles.
- Back-to-back transfers:
  - The master moves ENABLE->SETUP. The cycle after completion is a setup phase and is accepted from IDLE.
  - Minimum rate: 2 cycles per transfer at WAIT_CYCLES=0.
- Reads ignore PSTRB. A write with PSTRB=0 is a legal no-op completing with PSLVERR=0.
- PRDATA changes only on edges that raise PREADY. It is stable for the whole completion cycle.
- An erroring write never modifies memory.

Decomposition:
- Shared package apb_pkg holds:
  - the state enum (IDLE, ACCESS);
  - DATA_W=32, ADDR_W=32, STRB_W=4;
  - a function returning the index width from DEPTH.
- The master bridge uses the same package for its widths.
- One sub-module, apb_byte_regfile: DEPTH x 32 memory with synchronous reset clear, byte-enable write port and combinational read.
- The FSM, wait counter and decode stay in apb_slave_mem.

Test Plan:
- Basic round trip (WAIT_CYCLES=0): write 0xDEADBEEF to 0x0000_0010 with PSTRB=4'hF, then read 0x0000_0010.
  -> PREADY=1 in the first access cycle of each transfer; PRDATA=0xDEADBEEF; PSLVERR=0.
- Byte lanes: preload 0x11223344 at 0x04, then write 0xAABBCCDD with PSTRB=4'b0101, then read 0x04.
  -> PRDATA=0x11BB33DD.
- Wait states (WAIT_CYCLES=2): read 0x08 after writing 0x5A5A5A5A.
  -> PREADY low for 2 access cycles and high on the 3rd; PRDATA=0x5A5A5A5A only in that 3rd cycle.
- Errors (DEPTH=64):
  - Write 0x12345678 to 0x100. -> PSLVERR=1 with PREADY; mem[0] is unchanged (read 0x0 returns its prior value).
  - Read 0x02 (misaligned). -> PSLVERR=1 and PRDATA=0.
- Abort and reset: drop PSEL during ACCESS with WAIT_CYCLES=3.
  -> Returns to IDLE; no write occurs; the next setup is accepted.
  - Then assert PRESET mid-ACCESS. -> PREADY=0, PSLVERR=0, PRDATA=0, and all words read back as 0.
- Back-to-back with master_bridge: three consecutive writes, then three reads, with Trans held high.
  -> Each transfer completes in 2 cycles; read data matches the written data; PSEL-in-IDLE-with-PENABLE is ignored.
